uart_tx: RTL
============

Name: uart_tx

Overview:
- UART transmit path directly downstream of the UART register block.
- Accepts data-register writes into a 16-entry TX FIFO, or a 1-entry holding register when FIFOs are disabled.
- Generates the baud timing from the divisor and serialises frames (start, 5-8 data bits LSB first, optional parity, 1/1.5/2 stop) onto txd_out.
- Returns the THRE/TEMT status that the register block reports in its line status register.

Parameters:
FIFO_DEPTH, 16, TX FIFO entries when fifoen_in=1 (power of two)
IDLE_LEVEL, 1'b1, txd_out level when idle or held in reset

Ports:
apb_clk_in  input  1  block clock (same clock as the register block)
apb_rstn_in  input  1  reset, asynchronous, active-low
thr_wr_in  input  1  one-cycle pulse: write thr_in into the FIFO / holding register
thr_in  input  8  transmit byte
fifoen_in  input  1  1 = 16-entry FIFO mode, 0 = 1-entry holding register
txclr_in  input  1  one-cycle pulse: flush the FIFO
wls_in  input  2  word length: 0=5, 1=6, 2=7, 3=8 bits
stb_in  input  1  0 = 1 stop bit; 1 = 2 stop bits (1.5 stop bits when wls_in=0)
pen_in  input  1  parity enable
eps_in  input  1  even parity select
sp_in  input  1  stick parity
bc_in  input  1  break control: force txd_out low
dlr_in  input  16  baud divisor
osm_in  input  1  0 = 16x oversampling, 1 = 13x oversampling
utrst_in  input  1  0 = transmitter held in reset
txd_out  output  1  serial output
thre_out  output  1  FIFO / holding register empty
temt_out  output  1  FIFO empty and shifter idle
tx_count_out  output  5  current FIFO occupancy
tx_ovf_out  output  1  one-cycle pulse: write dropped because the FIFO was full

Behaviour:
- Clock and reset: one clock, apb_clk_in. apb_rstn_in is asynchronous and active-low.
- Reset values: txd_out=1, thre_out=1, temt_out=1, tx_count_out=0, tx_ovf_out=0. FSM=IDLE; prescaler, bit counter and FIFO pointers all 0.
- utrst_in=0: same effect as reset except config inputs are ignored. Applies even mid-frame: txd_out returns to 1 the next cycle.
- Prescaler:
  - Counts 0..dlr_in-1 and emits a sample tick on the wrap.
  - dlr_in=0: no ticks are generated; the FSM stalls in its current state.
  - The prescaler is cleared when a frame is loaded.
- Bit timing: one bit lasts N ticks, N=16 (osm_in=0) or 13 (osm_in=1). Bit period = dlr_in*N clocks.
- FSM states: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE, or back to START directly if the FIFO is non-empty at the end of STOP.
  - IDLE with count>0 and utrst_in=1: pop the head entry and latch wls/stb/pen/eps/sp/osm. txd_out goes 0 on the next cycle.
  - Config changes mid-frame take effect only at the next load.
- DATA: sends wls+5 bits, LSB first; unused upper bits of the byte are ignored.
- PARITY: skipped when pen=0. Parity bit values:
  - sp=0, eps=1: XOR of the data bits (even parity).
  - sp=0, eps=0: inverted XOR (odd parity).
  - sp=1: the bit equals ~eps.
- STOP length:
  - stb=0: N ticks.
  - stb=1 and wls=0: 24 ticks (16x) or 20 ticks (13x).
  - otherwise: 2N ticks.
- Break: bc_in=1 forces txd_out=0 combinationally after the output register. The FSM keeps running and frames are consumed.
- FIFO:
  - Effective depth is FIFO_DEPTH when fifoen_in=1, otherwise 1.
  - A write is accepted if count < depth, or if a pop occurs in the same cycle.
  - Otherwise the write is dropped and tx_ovf_out pulses for one cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - Changing fifoen_in flushes the FIFO.
- txclr_in: sets count and pointers to 0 on the next cycle. The frame already in progress completes. If txclr_in and thr_wr_in occur together, the clear wins and the write is dropped without a tx_ovf_out pulse.
- Status:
  - thre_out = (count==0).
  - temt_out = thre_out and FSM in IDLE.
  - Both are registered and updated the cycle after the causing event.

Test Plan:
- Basic 8N1 frame: dlr=1, osm=0, wls=3, pen=0, stb=0; write 0xA5 -> txd low 16 clks, then bits 1,0,1,0,0,1,0,1 at 16 clks each, then stop high 16 clks; temt=1 one cycle after STOP ends.
- Parity and stop length: wls=0, pen=1, eps=1, stb=1, osm=1, dlr=2; write 0x13 -> data 1,1,0,0,1 then parity 1, each bit 26 clks; stop high 40 clks.
- Stick parity and word length: sp=1, eps=0, wls=2; write 0x7F -> 7 data ones, parity 1. Repeat with eps=1 -> parity 0.
- FIFO boundaries: fifoen=1; write 17 bytes back-to-back while the first frame is active -> tx_count reaches 16, the 17th write pulses tx_ovf; all 16 bytes sent in order with no idle gap between frames.
- Holding-register mode: fifoen=0; two writes in consecutive cycles while IDLE -> first popped, second accepted via simultaneous pop; a third write during START pulses tx_ovf.
- Clears and resets: txclr mid-frame with 5 queued -> current frame completes, then idle, thre=1. utrst=0 mid-DATA -> txd=1 next cycle and temt=1. Async reset mid-frame -> all outputs at their reset values immediately. bc=1 -> txd held 0.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: TX FIFO / holding register, divisor-based baud prescaler and
// frame serialiser producing txd_out plus the THRE/TEMT line-status flags.
module uart_tx #(
  parameter int   FIFO_DEPTH = 16,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic        apb_clk_in,
  input  logic        apb_rstn_in,
  input  logic        thr_wr_in,
  input  logic [7:0]  thr_in,
  input  logic        fifoen_in,
  input  logic        txclr_in,
  input  logic [1:0]  wls_in,
  input  logic        stb_in,
  input  logic        pen_in,
  input  logic        eps_in,
  input  logic        sp_in,
  input  logic        bc_in,
  input  logic [15:0] dlr_in,
  input  logic        osm_in,
  input  logic        utrst_in,
  output logic        txd_out,
  output logic        thre_out,
  output logic        temt_out,
  output logic [4:0]  tx_count_out,
  output logic        tx_ovf_out
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  function automatic logic [5:0] bit_ticks(input logic osm);
    return osm ? 6'd13 : 6'd16;
  endfunction

  function automatic logic [5:0] stop_ticks(input logic osm, input logic stb, input logic [1:0] wls);
    if (!stb) return bit_ticks(osm);
    if (wls == 2'd0) return osm ? 6'd20 : 6'd24;
    return osm ? 6'd26 : 6'd32;
  endfunction

  function automatic logic parity_bit(input logic [7:0] d, input logic [1:0] wls,
                                      input logic eps, input logic sp);
    logic [7:0] m;
    m = d & (8'hFF >> (2'd3 - wls));
    return sp ? ~eps : ((^m) ^ ~eps);
  endfunction

  state_t          state, state_d;
  logic [15:0]     pcnt, pcnt_d;
  logic [5:0]      tcnt, tcnt_d, bit_len;
  logic [2:0]      bcnt, bcnt_d;
  logic [7:0]      shreg, shreg_d, head;
  logic [1:0]      wls_q, wls_d;
  logic            stb_q, stb_d, pen_q, pen_d, osm_q, osm_d, par_q, par_d;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [CW-1:0]   count, count_d, depth;
  logic            fifoen_q, txd_q, txd_d, thre_q, temt_q, ovf_q;
  logic            tick, bit_done, pop, clr, wr_ok, ovf_d;

  assign head     = mem[rptr];
  assign tick     = (dlr_in != 16'd0) && (pcnt >= dlr_in - 16'd1);
  assign bit_len  = (state == S_STOP) ? stop_ticks(osm_q, stb_q, wls_q) : bit_ticks(osm_q);
  assign bit_done = tick && (tcnt == bit_len - 6'd1);
  // A pop both loads the shifter and frees a slot for a same-cycle write.
  assign pop      = utrst_in && (count != '0) &&
                    ((state == S_IDLE) || ((state == S_STOP) && bit_done));
  assign clr      = txclr_in || (fifoen_in != fifoen_q) || !utrst_in;
  assign depth    = fifoen_in ? CW'(FIFO_DEPTH) : CW'(1);
  assign wr_ok    = thr_wr_in && !clr && ((count < depth) || pop);
  assign ovf_d    = thr_wr_in && !clr && !wr_ok;
  assign count_d  = clr ? '0 : count + CW'(wr_ok) - CW'(pop);

  always_comb begin
    state_d = state;
    pcnt_d  = pcnt;
    if (tick) pcnt_d = '0;
    else if (dlr_in != 16'd0) pcnt_d = pcnt + 16'd1;
    tcnt_d  = bit_done ? '0 : (tick ? tcnt + 6'd1 : tcnt);
    bcnt_d  = bcnt;
    shreg_d = shreg;
    par_d   = par_q;
    wls_d   = wls_q;
    stb_d   = stb_q;
    pen_d   = pen_q;
    osm_d   = osm_q;
    case (state)
      S_IDLE:   tcnt_d = '0;
      S_START:  if (bit_done) state_d = S_DATA;
      S_DATA:
        if (bit_done) begin
          if (bcnt == ({1'b0, wls_q} + 3'd4)) begin
            state_d = pen_q ? S_PARITY : S_STOP;
          end else begin
            bcnt_d  = bcnt + 3'd1;
            shreg_d = shreg >> 1;
          end
        end
      S_PARITY: if (bit_done) state_d = S_STOP;
      S_STOP:   if (bit_done) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (pop) begin
      state_d = S_START;
      pcnt_d  = '0;
      tcnt_d  = '0;
      bcnt_d  = '0;
      shreg_d = head;
      wls_d   = wls_in;
      stb_d   = stb_in;
      pen_d   = pen_in;
      osm_d   = osm_in;
      par_d   = parity_bit(head, wls_in, eps_in, sp_in);
    end
    if (!utrst_in) begin
      state_d = S_IDLE;
      pcnt_d  = '0;
      tcnt_d  = '0;
      bcnt_d  = '0;
    end
    // Output register follows the next state so txd changes with the state.
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shreg_d[0];
      S_PARITY: txd_d = par_d;
      S_STOP:   txd_d = 1'b1;
      default:  txd_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      state     <= S_IDLE;
      pcnt      <= '0;
      tcnt      <= '0;
      bcnt      <= '0;
      wls_q     <= '0;
      stb_q     <= 1'b0;
      pen_q     <= 1'b0;
      osm_q     <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      fifoen_q  <= 1'b0;
      txd_q     <= IDLE_LEVEL;
      thre_q    <= 1'b1;
      temt_q    <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state     <= state_d;
      pcnt      <= pcnt_d;
      tcnt      <= tcnt_d;
      bcnt      <= bcnt_d;
      wls_q     <= wls_d;
      stb_q     <= stb_d;
      pen_q     <= pen_d;
      osm_q     <= osm_d;
      wptr      <= clr ? '0 : (wr_ok ? wptr + AW'(1) : wptr);
      rptr      <= clr ? '0 : (pop ? rptr + AW'(1) : rptr);
      count     <= count_d;
      fifoen_q  <= fifoen_in;
      txd_q     <= txd_d;
      thre_q    <= (count_d == '0);
      temt_q    <= (count_d == '0) && (state_d == S_IDLE);
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge apb_clk_in) begin
    if (wr_ok) mem[wptr] <= thr_in;
    shreg <= shreg_d;
    par_q <= par_d;
  end

  assign txd_out      = bc_in ? 1'b0 : txd_q;
  assign thre_out     = thre_q;
  assign temt_out     = temt_q;
  assign tx_count_out = 5'(count);
  assign tx_ovf_out   = ovf_q;
endmodule
